parity_frame_checker: RTL

//  Downstream consumer of the XOR-reduction stage. Accumulates the per-word parity bit over a frame
//  of FRAME_LEN data beats, then compares it against a trailing check beat. Reports pass/fail per

---
 rtl/parity_frame_checker.sv | 99 +++++++++
 1 files changed

// File: rtl/parity_frame_checker.sv
// parity_frame_checker: accumulates per-beat parity over a frame and checks it against a trailing check beat
// Ports:
//   clock, resetN                  rising-edge clock, asynchronous active-low reset
//   inValid/inReady, parityBit     beat input (FRAME_LEN data beats, then one check beat)
//   frameAbort                     synchronous frame discard, overrides beat accept and result handshake
//   resultValid/resultReady        per-frame verdict handshake
//   resultError                    1 = parity mismatch, meaningful only while resultValid=1
//   errorCount                     saturating count of errored verdicts delivered
module parity_frame_checker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_WIDTH = 4,
    parameter int ERR_WIDTH = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic                 parityBit,
    input  logic                 frameAbort,
    output logic                 resultValid,
    input  logic                 resultReady,
    output logic                 resultError,
    output logic [ERR_WIDTH-1:0] errorCount
);
    typedef enum logic [1:0] {IDLE, ACCUM, CHECK, REPORT} state_t;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(FRAME_LEN);
    state_t               state_q, state_d;
    logic                 acc_q, acc_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 accept;
    // Gate ready with reset so no beat looks accepted while reset is held.
    assign inReady     = resetN && state_q != REPORT;
    assign accept      = inValid && inReady;
    assign resultValid = valid_q;
    assign resultError = err_q;
    assign errorCount  = err_cnt_q;
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        valid_d    = valid_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                acc_d      = parityBit;
                beat_cnt_d = CNT_WIDTH'(1);
                state_d    = (FRAME_LEN == 1) ? CHECK : ACCUM;
            end
            ACCUM: if (accept) begin
                acc_d      = acc_q ^ parityBit;
                beat_cnt_d = beat_cnt_q + 1'b1;
                state_d    = (beat_cnt_d == LAST_BEAT) ? CHECK : ACCUM;
            end
            CHECK: if (accept) begin
                err_d   = acc_q ^ parityBit ^ ODD_PARITY;
                valid_d = 1'b1;
                state_d = REPORT;
            end
            REPORT: if (resultReady) begin
                valid_d    = 1'b0;
                acc_d      = 1'b0;
                beat_cnt_d = '0;
                state_d    = IDLE;
                if (err_q && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything except the error count, which only reset clears.
        if (frameAbort) begin
            state_d    = IDLE;
            acc_d      = 1'b0;
            beat_cnt_d = '0;
            valid_d    = 1'b0;
            err_cnt_d  = err_cnt_q;
        end
    end
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            acc_q      <= 1'b0;
            beat_cnt_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
endmodule
